// File: rtl/wb_sdram_arbiter_if.sv
// Bundled Wishbone signals around the SDRAM arbiter: the per-master request
// vectors on one side, the single SDRAM slave port on the other.
// The slave modport is the arbiter's view (it is the slave of the masters).
// The master modport is the view of the surrounding masters and SDRAM model.
interface wb_sdram_arbiter_if #(
  parameter int NUM_MASTERS   = 4,
  parameter int data_width    = 32,
  parameter int address_width = 26
);
  logic [NUM_MASTERS-1:0]                  m_cyc_i;
  logic [NUM_MASTERS-1:0]                  m_stb_i;
  logic [NUM_MASTERS-1:0]                  m_we_i;
  logic [NUM_MASTERS*address_width-1:0]    m_addr_i;
  logic [NUM_MASTERS*data_width-1:0]       m_dat_i;
  logic [NUM_MASTERS*(data_width/8)-1:0]   m_sel_i;
  logic [NUM_MASTERS*3-1:0]                m_cti_i;
  logic [NUM_MASTERS-1:0]                  m_ack_o;
  logic [data_width-1:0]                   m_dat_o;
  logic [NUM_MASTERS-1:0]                  m_err_o;
  logic                                    s_cyc_o;
  logic                                    s_stb_o;
  logic                                    s_we_o;
  logic [address_width-1:0]                s_addr_o;
  logic [data_width-1:0]                   s_dat_o;
  logic [data_width/8-1:0]                 s_sel_o;
  logic [2:0]                              s_cti_o;
  logic                                    s_ack_i;
  logic [data_width-1:0]                   s_dat_i;
  logic [NUM_MASTERS-1:0]                  grant_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dat_i, m_sel_i, m_cti_i,
    input  s_ack_i, s_dat_i,
    output m_ack_o, m_dat_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o,
    output grant_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dat_i, m_sel_i, m_cti_i,
    output s_ack_i, s_dat_i,
    input  m_ack_o, m_dat_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o,
    input  grant_o
  );
endinterface

// File: rtl/wb_sdram_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller's Wishbone slave port
// between NUM_MASTERS masters. A grant is held for the whole bus cycle
// (bursts and stb gaps included) and released when the owner drops cyc.
// Optional bus watchdog: define WB_ARB_TIMEOUT_EN to abort a granted cycle
// that sees no ack for TIMEOUT cycles (m_err_o pulse, grant dropped).
//
// state | meaning
// IDLE  | no grant; arbitrate among pending cyc requests
// BUS   | one master owns the slave port until its cyc falls
module wb_sdram_arbiter #(
  parameter int NUM_MASTERS   = 4,
  parameter int data_width    = 32,
  parameter int address_width = 26,
  parameter int TIMEOUT       = 256
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  wb_sdram_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SEL_W = data_width / 8;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUS  = 1'b1;

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

  logic [0:0]             state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IDX_W-1:0]       gidx_q;
  logic [IDX_W-1:0]       last_q;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       cand;
  logic                   pick_valid;
  logic                   cyc_g;
  logic                   kill;

  assign cyc_g = bus.m_cyc_i[gidx_q];

  // Pick the first requester after the last owner, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = IDX_W'((int'(last_q) + i) % NUM_MASTERS);
      if (!pick_valid && bus.m_cyc_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CNT_W-1:0] tmo_q;

  // Watchdog down-counter: reloaded while idle and on every ack; reaching
  // zero in BUS without an ack aborts the cycle in that same clock.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      tmo_q <= '0;
    else if (state_q == IDLE || bus.s_ack_i)
      tmo_q <= CNT_W'(TIMEOUT - 1);
    else if (tmo_q != '0)
      tmo_q <= tmo_q - 1'b1;
  end

  assign kill = (state_q == BUS) && !bus.s_ack_i && (tmo_q == '0);
`else
  assign kill = 1'b0;
`endif

  // Grant FSM: register the winner, hold until its cyc drops (or watchdog).
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= LAST_RST;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q <= BUS;
            grant_q <= NUM_MASTERS'(1) << pick_idx;
            gidx_q  <= pick_idx;
          end
        end
        default: begin
          if (!cyc_g || kill) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= gidx_q;
          end
        end
      endcase
    end
  end

  // Request mux towards the slave and ack/err routing back to the owner only.
  always_comb begin
    bus.s_cyc_o  = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.s_we_o   = 1'b0;
    bus.s_addr_o = '0;
    bus.s_dat_o  = '0;
    bus.s_sel_o  = '0;
    bus.s_cti_o  = '0;
    bus.m_ack_o  = '0;
    bus.m_err_o  = '0;
    if (state_q == BUS) begin
      bus.s_cyc_o  = cyc_g & ~kill;
      bus.s_stb_o  = bus.m_stb_i[gidx_q] & ~kill;
      bus.s_we_o   = bus.m_we_i[gidx_q];
      bus.s_addr_o = bus.m_addr_i[gidx_q*address_width +: address_width];
      bus.s_dat_o  = bus.m_dat_i[gidx_q*data_width +: data_width];
      bus.s_sel_o  = bus.m_sel_i[gidx_q*SEL_W +: SEL_W];
      bus.s_cti_o  = bus.m_cti_i[gidx_q*3 +: 3];
      bus.m_ack_o[gidx_q] = bus.s_ack_i & ~kill;
      bus.m_err_o[gidx_q] = kill;
    end
  end

  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.grant_o = grant_q;
endmodule

// File: doc/wb_sdram_arbiter.md
Name: wb_sdram_arbiter

Overview:
- Round-robin arbiter that shares the single Wishbone slave port of the SDRAM controller between NUM_MASTERS Wishbone masters (e.g. CPU, DMA, video fetch).
- Grants one master per bus cycle and holds the grant for the full cycle, including bursts.
- Muxes the granted master's request signals onto the slave and routes the slave's ack back to that master only.
- Sits between the masters' Wishbone master ports and the SDRAM controller's Wishbone slave port, on the wb_clk_i domain.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- data_width, 32, Wishbone data width.
- address_width, 26, Wishbone address width.
- TIMEOUT, 256, watchdog limit in cycles (used only with the optional feature).

Ports:
- wb_clk_i  in  1  bus clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- m_cyc_i  in  NUM_MASTERS  per-master cyc.
- m_stb_i  in  NUM_MASTERS  per-master stb.
- m_we_i  in  NUM_MASTERS  per-master we.
- m_addr_i  in  NUM_MASTERS*address_width  per-master address; master k occupies slice k.
- m_dat_i  in  NUM_MASTERS*data_width  per-master write data.
- m_sel_i  in  NUM_MASTERS*(data_width/8)  per-master byte selects.
- m_cti_i  in  NUM_MASTERS*3  per-master cycle type.
- m_ack_o  out  NUM_MASTERS  per-master ack.
- m_dat_o  out  data_width  read data, broadcast to all masters.
- m_err_o  out  NUM_MASTERS  per-master error (driven only with the optional feature).
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to the SDRAM slave.
- s_addr_o  out  address_width  to the SDRAM slave.
- s_dat_o  out  data_width  to the SDRAM slave.
- s_sel_o  out  data_width/8  to the SDRAM slave.
- s_cti_o  out  3  to the SDRAM slave.
- s_ack_i  in  1  from the SDRAM slave.
- s_dat_i  in  data_width  from the SDRAM slave.
- grant_o  out  NUM_MASTERS  one-hot current grant (debug/perf).

Behaviour:
- Clock and reset: one clock, wb_clk_i; reset wb_rst_i is synchronous and active-high.
- Reset values: state=IDLE, grant_o=0, last-grant pointer=NUM_MASTERS-1 (so master 0 wins first), m_ack_o=0, m_err_o=0.
- Reset values, slave side: s_cyc_o/s_stb_o/s_we_o=0; s_addr_o/s_dat_o/s_sel_o/s_cti_o=0.
- FSM states: IDLE, BUS.
- IDLE, no request: if no m_cyc_i bit set, stay in IDLE.
- IDLE, requests pending: pick the first set m_cyc_i bit searching from (last+1) mod NUM_MASTERS upward with wrap; register its one-hot grant and go to BUS.
- Arbitration latency: exactly 1 cycle from IDLE with cyc asserted to s_cyc_o asserted.
- BUS, request path: s_cyc_o/s_stb_o/s_we_o/s_addr_o/s_dat_o/s_sel_o/s_cti_o are combinational copies of the granted master's signals.
- BUS, response path: m_ack_o[g]=s_ack_i; all other ack bits 0. m_dat_o=s_dat_i always.
- Grant hold: held while m_cyc_i[g]=1, independent of stb gaps and cti (burst 010 and end-of-burst 111 both keep the grant).
- Release: when m_cyc_i[g]=0, go to IDLE, set last=g, clear grant; s_cyc_o drops in that same cycle (combinational).
- Back-to-back requests: at least 1 IDLE cycle between grants.
- Starvation bound: with all masters requesting, each master waits at most NUM_MASTERS-1 other cycles.
- Cycle changes: requests changing while in BUS are ignored until IDLE.
- Reset mid-cycle: grant is dropped, s_cyc_o=0 on the next edge, no ack is forwarded afterwards, and the pointer returns to NUM_MASTERS-1.
- Unsolicited ack: s_ack_i asserted in IDLE is discarded (no m_ack_o).

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined: a counter clears on grant and on each s_ack_i, and increments every BUS cycle otherwise.
- On reaching TIMEOUT: m_err_o[g] pulses 1 cycle, the slave cyc/stb are forced to 0, the FSM goes to IDLE, and last=g.
- Required master reaction: the master must drop cyc on err.
- Not defined: no counter; m_err_o is tied to 0; the grant is held indefinitely.

Test Plan:
- Single master 0 writes addr 0x0000100 data 0xDEADBEEF.
  - Required response: s_cyc_o rises 1 cycle after m_cyc_i[0]; s_addr_o=0x0000100; m_ack_o[0] is high only when s_ack_i is; grant_o=0001.
- Masters 0–3 all assert cyc at the same cycle after reset.
  - Required response: grants occur in order 0,1,2,3, each separated by one IDLE cycle.
  - Then master 1 re-requests: granted before 0 only if 0 is not requesting; with 0 and 1 both requesting after 3, master 0 wins.
- Master 2 issues a 4-beat burst (cti 010,010,010,111) with stb dropped for 1 cycle mid-burst while master 1 requests.
  - Required response: grant stays 0100 until m_cyc_i[2] falls, then master 1 is granted.
- Master 3 reads while s_dat_i=0x12345678 with ack.
  - Required response: m_dat_o=0x12345678; m_ack_o=1000; masters 0–2 see no ack.
- wb_rst_i asserted 1 cycle in the middle of a master 1 cycle.
  - Required response: s_cyc_o=0 and grant_o=0 after the edge.
  - Next arbitration with masters 0 and 1 both requesting grants master 0.
- WB_ARB_TIMEOUT_EN with TIMEOUT=16: master 0 cycle with no s_ack_i.
  - Required response: m_err_o[0] pulses at cycle 16 of BUS; s_cyc_o drops; a pending master 1 is granted next.
